// File: rtl/memgame_pkg.sv
// Shared types and constants for the memory-game pattern checker.
// Pattern length is derived from the level reported by the level sequencer.
package memgame_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GEN,
      ST_SHOW,
      ST_GAP,
      ST_INPUT,
      ST_PASS,
      ST_FAIL,
      ST_OVER
   } state_e;

   localparam int         MAX_LEN    = 8;
   localparam int         SHOW_TICKS = 2;
   localparam logic [1:0] LIFE_INIT  = 2'd3;
   localparam logic [1:0] LAST_TICK  = 2'(SHOW_TICKS - 1);

   // Level 0..3 maps to pattern lengths 2, 4, 6, 8.
   function automatic logic [3:0] len_from_level(input logic [1:0] lvl);
      return {1'b0, lvl, 1'b0} + 4'd2;
   endfunction

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR (taps 8,6,5,4) used as the symbol source.
// It steps every cycle so the pattern depends on when the round starts.
module lfsr8 (
   input  logic       clk,
   input  logic       reset,
   output logic [7:0] q
);

   logic [7:0] q_q;
   logic [7:0] q_d;

   assign q_d = {q_q[6:0], q_q[7] ^ q_q[5] ^ q_q[4] ^ q_q[3]};
   assign q   = q_q;

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) q_q <= 8'hA5;
      else        q_q <= q_d;
   end

endmodule

// File: rtl/pattern_checker.sv
// Memory-game round controller: generates a pattern, shows it on en ticks,
// then checks the player's button replay and tracks remaining lives.
module pattern_checker
   import memgame_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       disp,
   input  logic [1:0] level,
   input  logic       btn_valid,
   input  logic [1:0] btn,
   output logic       ans,
   output logic [1:0] life,
   output logic       show_valid,
   output logic [1:0] show_sym,
   output logic       busy
);

   state_e     state_q, state_d;
   logic [2:0] idx_q, idx_d;
   logic [1:0] tick_q, tick_d;
   logic [3:0] len_q, len_d;
   logic [1:0] life_q, life_d;
   logic [1:0] pat_q [MAX_LEN];
   logic       pat_we;
   logic       last_idx;
   logic [7:0] lfsr;
   logic [5:0] lfsr_unused;

   lfsr8 u_lfsr (
      .clk   (clk),
      .reset (reset),
      .q     (lfsr)
   );

   assign lfsr_unused = lfsr[7:2];
   assign last_idx    = ({1'b0, idx_q} == len_q - 4'd1);
   assign busy        = (state_q != ST_IDLE) && (state_q != ST_OVER);
   assign life        = life_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         tick_q  <= '0;
         len_q   <= '0;
         life_q  <= LIFE_INIT;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         tick_q  <= tick_d;
         len_q   <= len_d;
         life_q  <= life_d;
      end
   end

   // NOTE: the pattern buffer is cleared on reset so a replay can never show
   // stale symbols; it is small enough that flops are the natural storage.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < MAX_LEN; i++) pat_q[i] <= '0;
      end else if (pat_we) begin
         pat_q[idx_q] <= lfsr[1:0];
      end
   end

   // NOTE: every output of this block gets a default first, so no path
   // through the case statement can leave a latch behind.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      tick_d     = tick_q;
      len_d      = len_q;
      life_d     = life_q;
      pat_we     = 1'b0;
      ans        = 1'b0;
      show_valid = 1'b0;
      show_sym   = '0;

      unique case (state_q)
         ST_IDLE: begin
            if (disp && en) begin
               len_d   = len_from_level(level);
               idx_d   = '0;
               state_d = ST_GEN;
            end
         end
         ST_GEN: begin
            pat_we = 1'b1;
            if (last_idx) begin
               idx_d   = '0;
               tick_d  = '0;
               state_d = ST_SHOW;
            end else begin
               idx_d = idx_q + 3'd1;
            end
         end
         ST_SHOW: begin
            show_valid = 1'b1;
            show_sym   = pat_q[idx_q];
            if (en) begin
               if (tick_q == LAST_TICK) begin
                  tick_d  = '0;
                  state_d = ST_GAP;
               end else begin
                  tick_d = tick_q + 2'd1;
               end
            end
         end
         ST_GAP: begin
            if (en) begin
               if (last_idx) begin
                  idx_d   = '0;
                  state_d = ST_INPUT;
               end else begin
                  idx_d   = idx_q + 3'd1;
                  state_d = ST_SHOW;
               end
            end
         end
         ST_INPUT: begin
            if (btn_valid) begin
               if (btn != pat_q[idx_q]) state_d = ST_FAIL;
               else if (last_idx)       state_d = ST_PASS;
               else                     idx_d   = idx_q + 3'd1;
            end
         end
         ST_PASS: begin
            ans = 1'b1;
            if (en) begin
               idx_d   = '0;
               state_d = ST_IDLE;
            end
         end
         ST_FAIL: begin
            // Saturating decrement: a life count of zero only exists in OVER.
            if (life_q != 2'd0) life_d = life_q - 2'd1;
            idx_d  = '0;
            tick_d = '0;
            if (life_q <= 2'd1) state_d = ST_OVER;
            else                state_d = ST_SHOW;
         end
         ST_OVER: begin
            state_d = ST_OVER;
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_pattern_checker.sv
// Scoreboard bench for pattern_checker: expected symbols are queued when the
// pattern is generated and popped by a monitor whenever a new symbol appears.
module tb_pattern_checker;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic       disp;
   logic [1:0] level;
   logic       btn_valid;
   logic [1:0] btn;
   logic       ans;
   logic [1:0] life;
   logic       show_valid;
   logic [1:0] show_sym;
   logic       busy;

   pattern_checker dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .disp       (disp),
      .level      (level),
      .btn_valid  (btn_valid),
      .btn        (btn),
      .ans        (ans),
      .life       (life),
      .show_valid (show_valid),
      .show_sym   (show_sym),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   localparam logic [7:0] TAP_MASK = 8'b1011_1000;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] m_lfsr;
   logic [1:0] m_life;
   logic [1:0] pat [8];
   logic [1:0] exp_q [$];
   bit         sv_prev = 1'b0;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] lfsr_step(input logic [7:0] s);
      return {s[6:0], ^(s & TAP_MASK)};
   endfunction

   // Monitor: each rising edge of show_valid marks the start of a new symbol.
   always @(negedge clk) begin
      if (!reset) begin
         sv_prev = 1'b0;
      end else begin
         if (show_valid && !sv_prev) begin
            if (exp_q.size() == 0) check("unexpected_show", 8'd1, 8'd0);
            else                   check("show_sym", {6'd0, show_sym}, {6'd0, exp_q.pop_front()});
         end
         sv_prev = show_valid;
      end
   end

   task automatic tick();
      @(posedge clk);
      if (reset) m_lfsr = lfsr_step(m_lfsr);
      #1;
   endtask

   task automatic gen_round(input logic [1:0] lv, output int n);
      n     = 2 * int'(lv) + 2;
      level = lv;
      disp  = 1'b1;
      en    = 1'b1;
      tick();
      disp  = 1'b0;
      en    = 1'b0;
      for (int i = 0; i < n; i++) begin
         check("gen_busy", {7'd0, busy}, 8'd1);
         pat[i] = m_lfsr[1:0];
         exp_q.push_back(pat[i]);
         tick();
      end
   endtask

   task automatic en_pulse(input bit poke);
      en = 1'b1;
      if (poke) begin
         btn_valid = 1'b1;
         btn       = 2'($urandom_range(3));
      end
      tick();
      en        = 1'b0;
      btn_valid = 1'b0;
      repeat (2) tick();
   endtask

   task automatic show_symbols(input int n, input bit poke);
      for (int i = 0; i < n; i++) begin
         check("show_on", {7'd0, show_valid}, 8'd1);
         en_pulse(poke);
         check("show_hold", {7'd0, show_valid}, 8'd1);
         en_pulse(poke);
         check("gap_off", {7'd0, show_valid}, 8'd0);
         en_pulse(poke);
      end
      check("input_noshow", {7'd0, show_valid}, 8'd0);
      check("input_busy", {7'd0, busy}, 8'd1);
      check("show_life", {6'd0, life}, {6'd0, m_life});
   endtask

   task automatic press(input logic [1:0] v);
      btn_valid = 1'b1;
      btn       = v;
      tick();
      btn_valid = 1'b0;
   endtask

   // wrong_at < 0 means the whole pattern is replayed correctly.
   task automatic answer(input int n, input int wrong_at);
      for (int i = 0; i < n; i++) begin
         if (i == wrong_at) begin
            if (m_life > 2'd1) for (int k = 0; k < n; k++) exp_q.push_back(pat[k]);
            press(pat[i] + 2'd1);
            check("fail_life_hold", {6'd0, life}, {6'd0, m_life});
            check("fail_ans", {7'd0, ans}, 8'd0);
            tick();
            m_life = m_life - 2'd1;
            check("life_dec", {6'd0, life}, {6'd0, m_life});
            if (m_life == 2'd0) check("over_busy", {7'd0, busy}, 8'd0);
            return;
         end
         press(pat[i]);
         if (i < n - 1) check("ans_early", {7'd0, ans}, 8'd0);
         else           check("ans_set", {7'd0, ans}, 8'd1);
         tick();
      end
      repeat (3) begin
         tick();
         check("ans_hold", {7'd0, ans}, 8'd1);
      end
      en = 1'b1;
      check("ans_en_cycle", {7'd0, ans}, 8'd1);
      tick();
      en = 1'b0;
      check("ans_clear", {7'd0, ans}, 8'd0);
      check("pass_idle", {7'd0, busy}, 8'd0);
      check("pass_life", {6'd0, life}, {6'd0, m_life});
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      m_lfsr = 8'hA5;
      m_life = 2'd3;
      exp_q.delete();
      repeat (2) tick();
      check("rst_ans", {7'd0, ans}, 8'd0);
      check("rst_life", {6'd0, life}, 8'd3);
      check("rst_show", {7'd0, show_valid}, 8'd0);
      check("rst_sym", {6'd0, show_sym}, 8'd0);
      check("rst_busy", {7'd0, busy}, 8'd0);
      reset = 1'b1;
   endtask

   initial begin
      int n;
      int j;
      en = 1'b0; disp = 1'b0; level = '0; btn_valid = 1'b0; btn = '0;
      apply_reset();
      tick();

      // Round at level 1, with button noise during display and disp during input.
      gen_round(2'd1, n);
      show_symbols(n, 1'b1);
      disp = 1'b1;
      en   = 1'b1;
      tick();
      disp = 1'b0;
      en   = 1'b0;
      check("disp_ignored", {7'd0, busy}, 8'd1);
      answer(n, -1);
      en = 1'b1;
      tick();
      en = 1'b0;
      check("idle_needs_disp", {7'd0, busy}, 8'd0);

      // Level 3, mistake on the third press, identical replay, then pass.
      gen_round(2'd3, n);
      show_symbols(n, 1'b0);
      answer(n, 2);
      show_symbols(n, 1'b0);
      answer(n, -1);

      // Level 0: two more mistakes exhaust the lives.
      repeat ($urandom_range(5)) tick();
      gen_round(2'd0, n);
      show_symbols(n, 1'b0);
      answer(n, 0);
      show_symbols(n, 1'b0);
      j = int'($urandom_range(1));
      answer(n, j);
      check("over_show", {7'd0, show_valid}, 8'd0);
      level = 2'd2;
      disp  = 1'b1;
      en    = 1'b1;
      tick();
      disp  = 1'b0;
      en    = 1'b0;
      press(2'($urandom_range(3)));
      repeat (4) tick();
      check("over_stuck_busy", {7'd0, busy}, 8'd0);
      check("over_stuck_life", {6'd0, life}, 8'd0);
      check("over_stuck_ans", {7'd0, ans}, 8'd0);
      check("over_stuck_show", {7'd0, show_valid}, 8'd0);
      check("queue_drained", 8'(exp_q.size()), 8'd0);

      // Fresh game at a random level, reset mid-input with idx at 2.
      apply_reset();
      repeat ($urandom_range(7)) tick();
      gen_round(2'(1 + $urandom_range(2)), n);
      show_symbols(n, 1'b0);
      for (int i = 0; i < 2; i++) begin
         press(pat[i]);
         tick();
      end
      check("pre_abort_busy", {7'd0, busy}, 8'd1);
      #2;
      reset = 1'b0;
      #1;
      check("abort_busy", {7'd0, busy}, 8'd0);
      check("abort_ans", {7'd0, ans}, 8'd0);
      check("abort_life", {6'd0, life}, 8'd3);
      check("abort_show", {7'd0, show_valid}, 8'd0);
      m_lfsr = 8'hA5;
      tick();
      reset = 1'b1;
      en = 1'b1;
      tick();
      en = 1'b0;
      tick();
      check("post_abort_idle", {7'd0, busy}, 8'd0);
      check("post_abort_ans", {7'd0, ans}, 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pattern_checker.md
PATTERN_CHECKER -- requirements
Module: pattern_checker

Interface
REQ-001 clk  input  1  system clock; all state updates on its rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 en  input  1  slow game tick, same tick that drives the level sequencer; one-cycle pulse.
REQ-004 disp  input  1  from level sequencer: start a new round (generate and show a pattern).
REQ-005 level  input  2  current level from level sequencer; selects pattern length.
REQ-006 btn_valid  input  1  one-cycle pulse: player pressed a button (debounced upstream).
REQ-007 btn  input  2  button code 0..3, valid when btn_valid=1.
REQ-008 ans  output  1  round passed; held until consumed by an en tick (REQ-020).
REQ-009 life  output  2  remaining lives; 0 = game over.
REQ-010 show_valid  output  1  a pattern symbol is being displayed.
REQ-011 show_sym  output  2  symbol being displayed, meaningful when show_valid=1.
REQ-012 busy  output  1  high in every state except IDLE and OVER.

Function
REQ-013 Pattern length SHALL be LEN = 2*level+2 (level 00->2, 01->4, 10->6, 11->8); max 8.
REQ-014 An 8-bit Fibonacci LFSR (taps 8,6,5,4), seed 8'hA5, SHALL advance every clk cycle regardless of state.
REQ-015 States: IDLE, GEN, SHOW, GAP, INPUT, PASS, FAIL, OVER.
REQ-016 IDLE: on disp=1 and en=1 latch LEN, go GEN; disp ignored in all other states.
REQ-017 GEN: one symbol per clk, symbol = lfsr[1:0], stored in 8x2 buffer at idx 0..LEN-1; after LEN cycles go SHOW, idx=0.
REQ-018 SHOW: show_valid=1, show_sym=buf[idx] for exactly SHOW_TICKS en pulses, then GAP for 1 en pulse (show_valid=0); idx++; after idx=LEN-1 go INPUT, idx=0.
REQ-019 INPUT: each btn_valid compares btn with buf[idx]; match and idx<LEN-1 -> idx++; match and idx=LEN-1 -> PASS; mismatch -> FAIL. btn_valid in any other state SHALL be ignored.
REQ-020 PASS: ans=1 from entry up to and including the first clk cycle with en=1, then ans=0, go IDLE; buffer not regenerated until next disp.
REQ-021 FAIL: life decremented by 1 in one cycle; if result 0 go OVER, else replay same pattern (SHOW, idx=0).
REQ-022 OVER: life=0, ans=0, show_valid=0; held until reset (level sequencer restarts on life==0).
REQ-023 life SHALL never underflow; no increment path exists.
REQ-024 btn_valid and en in the same cycle SHALL both take effect (en advances show timer only in SHOW/GAP).

Reset
REQ-025 While reset=0: state=IDLE, life=3, ans=0, show_valid=0, show_sym=0, busy=0, idx=0, LFSR=8'hA5, buffer cleared.
REQ-026 Reset asserted mid-round SHALL abort immediately with no ans pulse; first round after release needs a fresh disp.

Structure
REQ-027 Package memgame_pkg SHALL hold the state enum, MAX_LEN=8, SHOW_TICKS=2, LIFE_INIT=2'd3 and the LEN-from-level function.
REQ-028 The LFSR SHALL be a separate sub-module lfsr8 (clk, reset, q[7:0]); all else in pattern_checker.

Verification
REQ-029 Reset, level=01, disp+en -> 4 GEN cycles, 4 symbols each shown 2 en ticks + 1 gap tick, busy=1 throughout.
REQ-030 Replay the 4 shown symbols via btn -> ans=1 held until next en, then 0; life stays 3; state IDLE.
REQ-031 level=11, wrong btn on 3rd press -> life 3->2, same 8-symbol pattern re-shown identically.
REQ-032 Three wrong answers across rounds -> life 3->2->1->0, OVER, show_valid=0, further disp/btn ignored.
REQ-033 btn_valid pulses during SHOW/GAP -> no compare, no life change; disp during INPUT -> ignored.
REQ-034 Reset asserted during INPUT with idx=2 -> ans=0, life=3, IDLE immediately, asynchronously.
